mdu_unit: RTL and testbench

Multiply/divide unit in the EX stage of the pipelined MIPS core. It takes the two operands forwarded from the register-file read path and runs MULT/MULTU/DIV/DIVU as a fixed-latency multi-cycle operation. It also handles MTHI/MTLO writes. It holds HI/LO, which MFHI/MFLO carry down the pipeline to register writeback. The busy output, together with start, drives the ID-stage stall logic.

---
 rtl/mdu_unit.sv | 156 +++++++++++++++
 tb/tb_mdu_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// ============================================================================
// Module      : mdu_unit
// Description : EX-stage multiply/divide unit holding HI/LO, fixed-latency
//               MULT/MULTU/DIV/DIVU plus single-cycle MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        cancel,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] C_MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_N  = 4'(DIV_CYCLES);
  localparam logic [2:0] C_OP_MTHI = 3'd4;
  localparam logic [2:0] C_OP_MTLO = 3'd5;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [31:0] r_res_hi;
  logic [31:0] r_res_lo;
  logic        r_skip;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_accept;
  logic        w_load;
  logic        w_commit;
  logic        w_signed;
  logic        w_is_div;
  logic        w_div_zero;
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_b_safe;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q;
  logic [31:0] w_r;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign busy     = (r_state == S_RUN);
  assign w_accept = start & ~cancel & ~busy;
  assign w_signed = ~op[0];
  assign w_is_div = op[1];

  // One multiplier serves both forms: operands are sign- or zero-extended to 64 bits.
  assign w_a_ext = {{32{A[31] & w_signed}}, A};
  assign w_b_ext = {{32{B[31] & w_signed}}, B};
  assign w_prod  = w_a_ext * w_b_ext;

  // Signed divide on magnitudes keeps 0x80000000 / -1 well defined.
  assign w_a_neg    = w_signed & A[31];
  assign w_b_neg    = w_signed & B[31];
  assign w_a_mag    = w_a_neg ? (~A + 32'd1) : A;
  assign w_b_mag    = w_b_neg ? (~B + 32'd1) : B;
  assign w_div_zero = (B == 32'd0);
  assign w_b_safe   = w_div_zero ? 32'd1 : w_b_mag;
  assign w_q_mag    = w_a_mag / w_b_safe;
  assign w_r_mag    = w_a_mag % w_b_safe;
  assign w_q        = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r        = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;

  assign w_res_hi = w_is_div ? w_r : w_prod[63:32];
  assign w_res_lo = w_is_div ? w_q : w_prod[31:0];

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && !op[2]) begin
          w_load      = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == 4'd1) begin
          w_commit    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= 4'd0;
      r_res_hi <= 32'd0;
      r_res_lo <= 32'd0;
      r_skip   <= 1'b0;
    end else if (w_load) begin
      r_cnt    <= w_is_div ? C_DIV_N : C_MULT_N;
      r_res_hi <= w_res_hi;
      r_res_lo <= w_res_lo;
      r_skip   <= w_is_div & w_div_zero;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Commit and MTHI/MTLO are mutually exclusive: MT ops are accepted only when idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_skip) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end
    end else if (w_accept) begin
      if (op == C_OP_MTHI) r_hi <= A;
      if (op == C_OP_MTLO) r_lo <= A;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule

`default_nettype wire

// File: tb/tb_mdu_unit.sv
// ============================================================================
// Module      : tb_mdu_unit
// Description : Self-checking bench for mdu_unit (vector table + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic        cancel;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .cancel (cancel),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drives one op, pushes its expectation, then waits out busy and checks.
  // inj > 0 issues a DIVU start at that busy cycle, which must be ignored.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int ecyc, input int inj);
    exp_t        e;
    logic [31:0] h0;
    logic [31:0] l0;
    int          cyc;
    bit          held;
    @(negedge clk);
    h0 = hi;
    l0 = lo;
    op = o;
    A = a;
    B = b;
    start = 1'b1;
    e.hi = eh;
    e.lo = el;
    e.cyc = ecyc;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    held = 1'b1;
    while (busy && cyc < 40) begin
      cyc++;
      if (hi !== h0 || lo !== l0) held = 1'b0;
      if (cyc == inj) begin
        $display("note: %s start issued while busy at cycle %0d, must be ignored", name, cyc);
        start = 1'b1;
        op = 3'd3;
        A = 32'd100;
        B = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: scoreboard empty, got nothing, expected an entry", name);
    end else begin
      e = sb.pop_front();
      check_int({name, " busy_cycles"}, cyc, e.cyc);
      if (e.cyc > 0) check_int({name, " hold_during_busy"}, int'(held), 1);
      check32({name, " hi"}, hi, e.hi);
      check32({name, " lo"}, lo, e.lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int stay_idle;

    vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{3'd1, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3]  = '{3'd3, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5]  = '{3'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7]  = '{3'd3, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[8]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9]  = '{3'd4, 32'h00000011, 32'd0,        32'h00000011, 32'h00000001, 0};
    vecs[10] = '{3'd5, 32'h00000022, 32'd0,        32'h00000011, 32'h00000022, 0};
    vecs[11] = '{3'd2, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[12] = '{3'd3, 32'd5,        32'd0,        32'h00000011, 32'h00000022, 10};
    vecs[13] = '{3'd6, 32'hDEADBEEF, 32'd1,        32'h00000011, 32'h00000022, 0};
    vecs[14] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[15] = '{3'd0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'hFFFFFFFF, 5};

    reset = 1'b1;
    start = 1'b0;
    cancel = 1'b0;
    op = 3'd7;
    A = 32'd0;
    B = 32'd0;
    #3 reset = 1'b0;
    #1;
    check32("reset hi", hi, 32'd0);
    check32("reset lo", lo, 32'd0);
    check_int("reset busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].cyc, 0);
    end

    run_op("mthi", 3'd4, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 0, 0);
    run_op("mult_ovl", 3'd0, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, 5, 2);
    @(negedge clk);
    check_int("ignored_start busy", int'(busy), 0);

    @(negedge clk);
    start = 1'b1;
    cancel = 1'b1;
    op = 3'd0;
    A = 32'd2;
    B = 32'd2;
    @(negedge clk);
    check_int("cancel_mult busy", int'(busy), 0);
    op = 3'd5;
    A = 32'd99;
    @(negedge clk);
    start = 1'b0;
    cancel = 1'b0;
    check_int("cancel_mtlo busy", int'(busy), 0);
    check32("cancel hi", hi, 32'h00000000);
    check32("cancel lo", lo, 32'h0000000F);

    run_op("mthi_pre", 3'd4, 32'h000000AA, 32'd0, 32'h000000AA, 32'h0000000F, 0, 0);
    @(negedge clk);
    start = 1'b1;
    op = 3'd3;
    A = 32'd100;
    B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check_int("divu_pre_reset busy", int'(busy), 1);
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check32("midop_reset hi", hi, 32'd0);
    check32("midop_reset lo", lo, 32'd0);
    check_int("midop_reset busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    stay_idle = 1;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) stay_idle = 0;
    end
    check_int("post_reset idle", stay_idle, 1);
    check32("post_reset hi", hi, 32'd0);
    check32("post_reset lo", lo, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
